mips_run_monitor: RTL and testbench

- Synthesizable run controller and monitor for the MIPS core, for both simulation benches and FPGA bring-up.
- Sequences core reset for a programmable number of cycles, then lets the core run.
- Detects program completion as a PC self-loop (`j .`) or a timeout; counts cycles, retired instructions and stores.
- Folds all stores into a signature so benches compare one word instead of memory dumps.

---
 rtl/mips_run_monitor_if.sv | 23 ++
 rtl/mips_run_monitor.sv | 138 +++++++++++++
 tb/tb_mips_run_monitor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_run_monitor_if.sv
// Core-facing bus of the run monitor: retire/PC trace, store strobe and the
// core reset the monitor drives back.
interface mips_run_monitor_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
);
    logic              core_reset;
    logic [PC_W-1:0]   pc;
    logic              retire;
    logic              mem_write;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  core_reset,
        output pc, retire, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output core_reset,
        input  pc, retire, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_run_monitor.sv
// Run controller for the MIPS core: holds core reset, lets the core run, detects
// a `j .` halt or a timeout, and counts cycles, retires and stores into a signature.
module mips_run_monitor #(
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 750,
    parameter int HALT_REPEAT  = 4,
    parameter int PC_W         = 32,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    mips_run_monitor_if.slave   core,
    output logic                running,
    output logic                done,
    output logic                timeout,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    retire_count,
    output logic [CNT_W-1:0]    store_count,
    output logic [DATA_W-1:0]   signature,
    output logic [PC_W-1:0]     halt_pc
);

    localparam int RT_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int REP_W = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {IDLE, RSTH, RUN, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [RT_W-1:0]   rst_timer;
    logic [PC_W-1:0]   last_pc;
    logic [REP_W-1:0]  rep_cnt;
    logic [CNT_W-1:0]  cycle_next;
    logic              pc_repeat;
    logic              halt_hit;
    logic              timeout_hit;
    logic              reset_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // A cleared last_pc/rep_cnt pair behaves like "no prior retire": the first
    // retire always ends with rep_cnt == 1 whether or not pc matches 0.
    always_comb begin
        pc_repeat   = core.retire && (core.pc == last_pc);
        halt_hit    = pc_repeat && (rep_cnt == REP_W'(HALT_REPEAT - 1));
        cycle_next  = sat_inc(cycle_count);
        timeout_hit = (cycle_next == CNT_W'(MAX_CYCLES));
        reset_done  = (rst_timer == RT_W'(RESET_CYCLES - 1));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RSTH;
            RSTH:    if (reset_done) state_next = RUN;
            RUN:     if (halt_hit || timeout_hit) state_next = DONE;
            DONE:    if (start) state_next = RSTH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        core.core_reset = (state != RUN);
        running         = (state == RUN);
        done            = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rst_timer    <= '0;
            last_pc      <= '0;
            rep_cnt      <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            store_count  <= '0;
            signature    <= '0;
            halt_pc      <= '0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rst_timer    <= '0;
                        last_pc      <= '0;
                        rep_cnt      <= '0;
                        cycle_count  <= '0;
                        retire_count <= '0;
                        store_count  <= '0;
                        signature    <= '0;
                        halt_pc      <= '0;
                        timeout      <= 1'b0;
                    end
                end
                RSTH: begin
                    if (!reset_done) rst_timer <= rst_timer + RT_W'(1);
                end
                RUN: begin
                    cycle_count <= cycle_next;
                    if (core.retire) begin
                        retire_count <= sat_inc(retire_count);
                        if (pc_repeat) begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                        end else begin
                            last_pc <= core.pc;
                            rep_cnt <= REP_W'(1);
                        end
                    end
                    if (core.mem_write) begin
                        store_count <= sat_inc(store_count);
                        signature   <= {signature[DATA_W-2:0], signature[DATA_W-1]}
                                       ^ core.mem_addr ^ core.mem_wdata;
                    end
                    // Halt takes precedence when both end conditions land together.
                    if (halt_hit) begin
                        halt_pc <= core.pc;
                        timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: a vector table for start/halt/stores,
// then hand sequences for retire gaps, mid-run reset and timeout.
module tb_mips_run_monitor;

    logic        clock;
    logic        reset;
    logic        start;
    logic        running;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [31:0] retire_count;
    logic [31:0] store_count;
    logic [31:0] signature;
    logic [31:0] halt_pc;

    int assertions = 0;
    int failures   = 0;

    mips_run_monitor_if #(.PC_W(32), .DATA_W(32)) bus ();

    mips_run_monitor #(
        .RESET_CYCLES(2),
        .MAX_CYCLES  (750),
        .HALT_REPEAT (4),
        .PC_W        (32),
        .DATA_W      (32),
        .CNT_W       (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .core        (bus.slave),
        .running     (running),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .retire_count(retire_count),
        .store_count (store_count),
        .signature   (signature),
        .halt_pc     (halt_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        start;
        logic        retire;
        logic [31:0] pc;
        logic        mem_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_core_reset;
        logic        exp_running;
        logic        exp_done;
        logic        exp_timeout;
        logic [31:0] exp_cycle;
        logic [31:0] exp_retire;
        logic [31:0] exp_store;
        logic [31:0] exp_sig;
        logic [31:0] exp_halt_pc;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic setBus(input logic st, input logic ret, input logic [31:0] pc,
                          input logic mw, input logic [31:0] addr, input logic [31:0] wdata);
        start         = st;
        bus.retire    = ret;
        bus.pc        = pc;
        bus.mem_write = mw;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
    endtask

    task automatic checkAll(input string tag, input vec_t v);
        checkOutput({tag, ".core_reset"}, 32'(bus.core_reset), 32'(v.exp_core_reset));
        checkOutput({tag, ".running"},    32'(running),        32'(v.exp_running));
        checkOutput({tag, ".done"},       32'(done),           32'(v.exp_done));
        checkOutput({tag, ".timeout"},    32'(timeout),        32'(v.exp_timeout));
        checkOutput({tag, ".cycle"},      cycle_count,         v.exp_cycle);
        checkOutput({tag, ".retire"},     retire_count,        v.exp_retire);
        checkOutput({tag, ".store"},      store_count,         v.exp_store);
        checkOutput({tag, ".sig"},        signature,           v.exp_sig);
        checkOutput({tag, ".halt_pc"},    halt_pc,             v.exp_halt_pc);
    endtask

    task automatic applyStimulus(input int idx);
        setBus(vecs[idx].start, vecs[idx].retire, vecs[idx].pc,
               vecs[idx].mem_write, vecs[idx].addr, vecs[idx].wdata);
        tick();
        checkAll($sformatf("vec%0d", idx), vecs[idx]);
    endtask

    task automatic startRun();
        setBus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    vec_t        zero_v;
    logic [8:0]  gap_pat;
    int          run_cycles;

    initial begin
        //                st ret pc      mw addr    wdata   cr run dn to cyc ret st sig     hpc
        vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 32'h0,   32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 32'h0,   32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 32'h0,   32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0, 1'b1, 32'h10, 32'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1, 32'hB5,  32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h14, 32'h01, 1'b0, 1'b1, 1'b0, 1'b0, 2, 2, 2, 32'h17F, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 3, 3, 2, 32'h17F, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'hC, 1'b0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 4, 4, 2, 32'h17F, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'hC, 1'b0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 5, 5, 2, 32'h17F, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'hC, 1'b0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 6, 6, 2, 32'h17F, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'hC, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 7, 7, 2, 32'h17F, 32'hC};
        vecs[10] = '{1'b0, 1'b1, 32'hC, 1'b1, 32'h50, 32'h7,  1'b1, 1'b0, 1'b1, 1'b0, 7, 7, 2, 32'h17F, 32'hC};
        zero_v   = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 32'h0,   32'h0};

        reset = 1'b0;
        setBus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkAll("reset", zero_v);
        reset = 1'b1;
        tick();
        checkAll("idle", zero_v);

        // Start, two reset cycles, stores, start ignored in RUN, halt on 0xC, hold in DONE
        for (int i = 0; i < 11; i++) applyStimulus(i);

        // Restart from DONE clears everything; then halt on 0x20 with retire gaps
        setBus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        checkAll("restart", zero_v);
        start = 1'b0;
        tick();
        tick();
        checkOutput("restart.running", 32'(running), 32'd1);
        gap_pat = 9'b100010101;
        for (int i = 0; i < 9; i++) begin
            setBus(1'b0, gap_pat[i], 32'h20, 1'b0, 32'h0, 32'h0);
            tick();
            checkOutput($sformatf("gap%0d.done", i), 32'(done), (i == 8) ? 32'd1 : 32'd0);
        end
        checkOutput("gap.halt_pc", halt_pc,      32'h20);
        checkOutput("gap.retire",  retire_count, 32'd4);
        checkOutput("gap.cycle",   cycle_count,  32'd9);
        checkOutput("gap.timeout", 32'(timeout), 32'd0);

        // Reset for one cycle mid-run returns every output to its reset value
        startRun();
        for (int i = 0; i < 3; i++) begin
            setBus(1'b0, 1'b1, 32'h40 + 32'(i * 4), 1'b1, 32'h80, 32'h3);
            tick();
        end
        checkOutput("midrun.store", store_count, 32'd3);
        reset = 1'b0;
        setBus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        checkAll("midreset", zero_v);
        reset = 1'b1;
        tick();
        checkAll("postreset", zero_v);

        // Timeout after MAX_CYCLES with ever-changing pc
        startRun();
        run_cycles = 0;
        for (int i = 0; i < 800 && !done; i++) begin
            setBus(1'b0, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 32'h0, 32'h0);
            tick();
            run_cycles++;
        end
        checkOutput("to.done",       32'(done),            32'd1);
        checkOutput("to.timeout",    32'(timeout),         32'd1);
        checkOutput("to.run_cycles", 32'(run_cycles),      32'd750);
        checkOutput("to.cycle",      cycle_count,          32'd750);
        checkOutput("to.retire",     retire_count,         32'd750);
        checkOutput("to.core_reset", 32'(bus.core_reset),  32'd1);
        checkOutput("to.halt_pc",    halt_pc,              32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
